// File: rtl/imem_boot_loader.sv
// Packs a byte stream big-endian into 32-bit words and writes them to inst_ram from BASE_ADDR, holding the core in reset until done.
// Latency: 4th byte accepted at edge N, RAM write presented N+1..N+2; byte_ready drops while a word is being written.
module imem_boot_loader #(
    parameter int unsigned NUM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    localparam int WCW = $clog2(NUM_WORDS + 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);
    localparam logic [31:0]    TO_LAST   = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERROR} state_t;

    state_t         state;
    logic [WCW-1:0] word_cnt;
    logic [1:0]     byte_cnt;
    logic [31:0]    idle_cnt;
    logic [31:0]    word;
    logic           wr_phase;
    logic           accept;

    assign accept = byte_valid & byte_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 4'h0;
            ram_addr   <= 32'h0;
            ram_din    <= 32'h0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_cnt   <= '0;
            byte_cnt   <= 2'd0;
            idle_cnt   <= 32'd0;
            word       <= 32'h0;
            wr_phase   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (load_start) begin
                        state      <= COLLECT;
                        byte_ready <= 1'b1;
                        ram_addr   <= BASE_ADDR;
                        word_cnt   <= '0;
                        byte_cnt   <= 2'd0;
                        idle_cnt   <= 32'd0;
                        wr_phase   <= 1'b0;
                        error      <= 1'b0;
                        done       <= 1'b0;
                        cpu_rst    <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        word     <= {word[23:0], byte_in};
                        idle_cnt <= 32'd0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                        end
                    end else if (TIMEOUT != 0 && idle_cnt == TO_LAST) begin
                        // partially packed bytes are simply abandoned
                        state      <= ERROR;
                        error      <= 1'b1;
                        byte_ready <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                WRITE: begin
                    // phase 0 presents the write for one full cycle, phase 1 retires it
                    if (!wr_phase) begin
                        ram_en   <= 1'b1;
                        ram_we   <= 4'hF;
                        ram_din  <= word;
                        wr_phase <= 1'b1;
                    end else begin
                        ram_en   <= 1'b0;
                        ram_we   <= 4'h0;
                        wr_phase <= 1'b0;
                        ram_addr <= ram_addr + 32'd4;
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state      <= COLLECT;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: byte images are packed by a reference model and compared with observed RAM writes.
module tb_imem_boot_loader;

    localparam int          NW   = 2;
    localparam int          TO   = 16;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int total  = 0;
    int passed = 0;

    logic [7:0]  img [0:4*NW-1];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_din_q[$];
    logic [3:0]  wr_we_q[$];

    imem_boot_loader #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .ram_en(ram_en),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Records every cycle with any RAM write activity, sampled where the RAM samples.
    always @(negedge clk) begin
        if (ram_en === 1'b1 || ram_we !== 4'h0) begin
            wr_addr_q.push_back(ram_addr);
            wr_din_q.push_back(ram_din);
            wr_we_q.push_back(ram_we);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_din_q.delete();
        wr_we_q.delete();
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic rand_image();
        foreach (img[k]) img[k] = 8'($urandom);
    endtask

    // Offers img[first..last]; returns just after the edge that accepted img[last].
    task automatic send_bytes(input int first, input int last, input int gap_max);
        int i;
        int budget;
        logic acc;
        i = first;
        budget = 0;
        while (i <= last && budget < 500) begin
            byte_valid = 1'b1;
            byte_in    = img[i];
            acc        = byte_ready;
            tick();
            budget++;
            if (acc) begin
                i++;
                if (i <= last && (i % 4) != 0 && gap_max > 0) begin
                    byte_valid = 1'b0;
                    byte_in    = 8'($urandom);
                    repeat ($urandom_range(gap_max, 0)) tick();
                end
            end
        end
        byte_valid = 1'b0;
        total++;
        if (i <= last) $display("FAIL send_bytes_stall: sent up to %0d want %0d", i, last + 1);
        else passed++;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_in = 8'h0;
        tick();
        tick();
        total++; if (byte_ready !== 1'b0) $display("FAIL rst_byte_ready: got %b want 0", byte_ready); else passed++;
        total++; if (ram_en !== 1'b0) $display("FAIL rst_ram_en: got %b want 0", ram_en); else passed++;
        total++; if (ram_we !== 4'h0) $display("FAIL rst_ram_we: got %h want 0", ram_we); else passed++;
        total++; if (ram_addr !== 32'h0) $display("FAIL rst_ram_addr: got %h want 0", ram_addr); else passed++;
        total++; if (ram_din !== 32'h0) $display("FAIL rst_ram_din: got %h want 0", ram_din); else passed++;
        total++; if (cpu_rst !== 1'b1) $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
        total++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else passed++;
        rst = 1'b0;
        tick();
        tick();
        total++; if (byte_ready !== 1'b0 || cpu_rst !== 1'b1) $display("FAIL idle_hold: ready=%b cpu_rst=%b want 0/1", byte_ready, cpu_rst); else passed++;
    endtask

    task automatic test_fixed_image();
        logic [31:0] ew;
        logic [31:0] ea;
        img[0] = 8'h20; img[1] = 8'h08; img[2] = 8'h00; img[3] = 8'h05;
        img[4] = 8'h21; img[5] = 8'h09; img[6] = 8'h00; img[7] = 8'h0A;
        clear_writes();
        pulse_load();
        total++; if (byte_ready !== 1'b1 || cpu_rst !== 1'b1) $display("FAIL fixed_collect: ready=%b cpu_rst=%b want 1/1", byte_ready, cpu_rst); else passed++;
        send_bytes(0, 7, 0);
        total++; if (ram_en !== 1'b0 || byte_ready !== 1'b0) $display("FAIL fixed_lat_n: ram_en=%b ready=%b want 0/0", ram_en, byte_ready); else passed++;
        tick();
        total++; if (ram_en !== 1'b1 || ram_we !== 4'hF || ram_din !== 32'h2109000A || ram_addr !== 32'h4)
            $display("FAIL fixed_lat_n1: en=%b we=%h din=%h addr=%h want 1/F/2109000a/4", ram_en, ram_we, ram_din, ram_addr); else passed++;
        total++; if (done !== 1'b0 || cpu_rst !== 1'b1) $display("FAIL fixed_early_done: done=%b cpu_rst=%b want 0/1", done, cpu_rst); else passed++;
        tick();
        total++; if (done !== 1'b1 || cpu_rst !== 1'b0 || ram_en !== 1'b0) $display("FAIL fixed_done: done=%b cpu_rst=%b en=%b want 1/0/0", done, cpu_rst, ram_en); else passed++;
        total++; if (wr_din_q.size() != NW) $display("FAIL fixed_wr_count: got %0d want %0d", wr_din_q.size(), NW); else passed++;
        for (int w = 0; w < NW && w < wr_din_q.size(); w++) begin
            ew = {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]};
            ea = BASE + 32'(4 * w);
            total++;
            if (wr_din_q[w] !== ew || wr_addr_q[w] !== ea || wr_we_q[w] !== 4'hF)
                $display("FAIL fixed_word%0d: din=%h addr=%h we=%h want %h/%h/F", w, wr_din_q[w], wr_addr_q[w], wr_we_q[w], ew, ea);
            else passed++;
        end
    endtask

    task automatic test_gaps();
        logic [31:0] ew;
        int cyc;
        clear_writes();
        pulse_load();
        total++; if (cpu_rst !== 1'b1 || done !== 1'b0) $display("FAIL gaps_reload: cpu_rst=%b done=%b want 1/0", cpu_rst, done); else passed++;
        send_bytes(0, 7, 4);
        wait_done(cyc);
        total++; if (done !== 1'b1 || cpu_rst !== 1'b0) $display("FAIL gaps_done: done=%b cpu_rst=%b want 1/0", done, cpu_rst); else passed++;
        total++; if (wr_din_q.size() != NW) $display("FAIL gaps_wr_count: got %0d want %0d", wr_din_q.size(), NW); else passed++;
        for (int w = 0; w < NW && w < wr_din_q.size(); w++) begin
            ew = {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]};
            total++;
            if (wr_din_q[w] !== ew || wr_addr_q[w] !== BASE + 32'(4 * w))
                $display("FAIL gaps_word%0d: din=%h addr=%h want %h/%h", w, wr_din_q[w], wr_addr_q[w], ew, BASE + 32'(4 * w));
            else passed++;
        end
    endtask

    task automatic test_timeout();
        logic [31:0] ew;
        int n;
        int cyc;
        rand_image();
        clear_writes();
        pulse_load();
        send_bytes(0, 1, 0);
        repeat (TO - 2) tick();
        total++; if (error !== 1'b0) $display("FAIL to_early: error=%b want 0", error); else passed++;
        n = 0;
        while (error !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        total++; if (error !== 1'b1) $display("FAIL to_error: error=%b want 1", error); else passed++;
        total++; if (cpu_rst !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL to_state: cpu_rst=%b ready=%b done=%b want 1/0/0", cpu_rst, byte_ready, done); else passed++;
        total++; if (wr_din_q.size() != 0) $display("FAIL to_no_write: got %0d writes want 0", wr_din_q.size()); else passed++;
        rand_image();
        pulse_load();
        total++; if (error !== 1'b0 || byte_ready !== 1'b1) $display("FAIL to_restart: error=%b ready=%b want 0/1", error, byte_ready); else passed++;
        send_bytes(0, 4*NW-1, 3);
        wait_done(cyc);
        total++; if (done !== 1'b1 || cpu_rst !== 1'b0) $display("FAIL to_reload_done: done=%b cpu_rst=%b want 1/0", done, cpu_rst); else passed++;
        total++; if (wr_din_q.size() != NW) $display("FAIL to_wr_count: got %0d want %0d", wr_din_q.size(), NW); else passed++;
        for (int w = 0; w < NW && w < wr_din_q.size(); w++) begin
            ew = {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]};
            total++;
            if (wr_din_q[w] !== ew || wr_addr_q[w] !== BASE + 32'(4 * w))
                $display("FAIL to_word%0d: din=%h addr=%h want %h/%h", w, wr_din_q[w], wr_addr_q[w], ew, BASE + 32'(4 * w));
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ew;
        rand_image();
        clear_writes();
        pulse_load();
        send_bytes(0, 3, 0);
        tick();
        total++; if (ram_en !== 1'b1) $display("FAIL mid_write: ram_en=%b want 1", ram_en); else passed++;
        rst = 1'b1;
        tick();
        total++; if (ram_we !== 4'h0 || ram_en !== 1'b0) $display("FAIL mid_rst_we: en=%b we=%h want 0/0", ram_en, ram_we); else passed++;
        total++; if (cpu_rst !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0)
            $display("FAIL mid_rst_state: cpu_rst=%b done=%b ready=%b want 1/0/0", cpu_rst, done, byte_ready); else passed++;
        total++; if (ram_addr !== 32'h0) $display("FAIL mid_rst_addr: got %h want 0", ram_addr); else passed++;
        rst = 1'b0;
        repeat (3) tick();
        ew = {img[0], img[1], img[2], img[3]};
        total++; if (wr_din_q.size() != 1) $display("FAIL mid_wr_count: got %0d want 1", wr_din_q.size());
        else if (wr_din_q[0] !== ew) $display("FAIL mid_word0: got %h want %h", wr_din_q[0], ew);
        else passed++;
        total++; if (cpu_rst !== 1'b1 || byte_ready !== 1'b0) $display("FAIL mid_idle: cpu_rst=%b ready=%b want 1/0", cpu_rst, byte_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ew;
        int cyc;
        for (int pass = 0; pass < 3; pass++) begin
            rand_image();
            clear_writes();
            pulse_load();
            total++; if (cpu_rst !== 1'b1 || done !== 1'b0) $display("FAIL b2b_start%0d: cpu_rst=%b done=%b want 1/0", pass, cpu_rst, done); else passed++;
            send_bytes(0, 4*NW-1, (pass == 0) ? 0 : 5);
            wait_done(cyc);
            total++; if (done !== 1'b1 || cpu_rst !== 1'b0) $display("FAIL b2b_done%0d: done=%b cpu_rst=%b want 1/0", pass, done, cpu_rst); else passed++;
            total++; if (wr_din_q.size() != NW) $display("FAIL b2b_count%0d: got %0d want %0d", pass, wr_din_q.size(), NW); else passed++;
            for (int w = 0; w < NW && w < wr_din_q.size(); w++) begin
                ew = {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]};
                total++;
                if (wr_din_q[w] !== ew || wr_addr_q[w] !== BASE + 32'(4 * w) || wr_we_q[w] !== 4'hF)
                    $display("FAIL b2b_word%0d_%0d: din=%h addr=%h we=%h want %h/%h/F", pass, w, wr_din_q[w], wr_addr_q[w], wr_we_q[w], ew, BASE + 32'(4 * w));
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_image();
        test_gaps();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
